imem_loader: RTL

- Boot-time writer for the instruction memory, which the core otherwise only reads.
- Accepts a framed byte stream over a valid/ready input and assembles big-endian 16-bit instruction words.
- Writes those words to consecutive imem addresses from 0, verifies a 16-bit additive checksum, and holds the core in reset until a load completes cleanly.
- Sits between the host byte source (UART/debug bridge) and the imem write port / core reset.

---
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the boot loader.
// The host side drives the stream; the loader side drives the imem write port.
interface imem_loader_if #(parameter int ADDR_W = 8);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [15:0]       imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time imem writer: parses a length/data/checksum byte frame, writes
// big-endian 16-bit words from address 0, and holds the core until a clean load.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    imem_loader_if.slave bus,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    typedef enum logic [3:0] {
        ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO,
        ST_CSUM_HI, ST_CSUM_LO, ST_DONE, ST_ERROR
    } state_t;

    state_t          state, next_state;
    logic [7:0]      hi_byte;
    logic [15:0]     len;
    logic [ADDR_W:0] idx;
    logic [15:0]     sum;

    logic        accept;
    logic [15:0] pair;
    logic        start_go;
    logic        wr;
    logic        last_word;

    function automatic logic rx_state(state_t s);
        return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO,
                         ST_CSUM_HI, ST_CSUM_LO};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        start_go   = 1'b0;
        wr         = 1'b0;
        accept     = bus.in_valid && bus.in_ready;
        // every byte pair (length, data word, checksum) is hi byte then current byte
        pair       = {hi_byte, bus.in_data};
        last_word  = (17'(idx) + 17'd1) == {1'b0, len};
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    next_state = ST_LEN_HI;
                    start_go   = 1'b1;
                end
            end
            ST_LEN_HI:  if (accept) next_state = ST_LEN_LO;
            ST_LEN_LO: begin
                if (accept) begin
                    if ({1'b0, pair} > MAX_WORDS) next_state = ST_ERROR;
                    else if (pair == 16'd0)       next_state = ST_CSUM_HI;
                    else                          next_state = ST_DATA_HI;
                end
            end
            ST_DATA_HI: if (accept) next_state = ST_DATA_LO;
            ST_DATA_LO: begin
                if (accept) begin
                    wr         = 1'b1;
                    next_state = last_word ? ST_CSUM_HI : ST_DATA_HI;
                end
            end
            ST_CSUM_HI: if (accept) next_state = ST_CSUM_LO;
            ST_CSUM_LO: begin
                if (accept) next_state = (pair == sum) ? ST_DONE : ST_ERROR;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_waddr <= '0;
            bus.imem_wdata <= '0;
            cpu_hold       <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            err_code       <= 2'd0;
            hi_byte        <= '0;
            len            <= '0;
            idx            <= '0;
            sum            <= '0;
        end else begin
            // ready and busy cover exactly the same states
            bus.in_ready <= rx_state(next_state);
            busy         <= rx_state(next_state);
            bus.imem_we  <= wr;

            if (accept && (state inside {ST_LEN_HI, ST_DATA_HI, ST_CSUM_HI}))
                hi_byte <= bus.in_data;
            if (accept && state == ST_LEN_LO)
                len <= pair;

            if (start_go) begin
                idx            <= '0;
                sum            <= '0;
                bus.imem_waddr <= '0;
                cpu_hold       <= 1'b1;
                done           <= 1'b0;
                err            <= 1'b0;
                err_code       <= 2'd0;
            end

            if (wr) begin
                bus.imem_waddr <= idx[ADDR_W-1:0];
                bus.imem_wdata <= pair;
                sum            <= sum + pair;
                idx            <= idx + 1'b1;
            end

            if (next_state == ST_ERROR && state != ST_ERROR) begin
                err      <= 1'b1;
                err_code <= (state == ST_LEN_LO) ? 2'd1 : 2'd2;
            end

            if (next_state == ST_DONE && state == ST_CSUM_LO) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
        end
    end
endmodule
